lm_sm_seq_gen: RTL and testbench

- Parametrised load-multiple/store-multiple micro-op sequencer that sits between decode and register-read.
- Accepts one LM/SM instruction: register mask, base address, direction.
- Emits one register-transfer micro-op per set mask bit, in priority order, with an auto-incrementing address and a valid/ready handshake to the next stage.
- Stalls the upstream stages until the final micro-op is accepted.

---
 rtl/lm_sm_seq_gen.sv | 192 +++++++++++++++++++
 tb/tb_lm_sm_seq_gen.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/lm_sm_seq_gen.sv
// Load-multiple/store-multiple micro-op sequencer: expands one register mask into per-register transfers.
// Optional base write-back micro-op is enabled by defining LM_SM_WRITEBACK_EN.
module lm_sm_seq_gen #(
    parameter int NUM_REGS  = 8,
    parameter int IDX_W     = 3,
    parameter int ADDR_W    = 16,
    parameter int ADDR_STEP = 1,
    parameter int LSB_FIRST = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                is_store,
    input  logic [NUM_REGS-1:0] reg_mask,
    input  logic [ADDR_W-1:0]   base_addr,
    input  logic [IDX_W-1:0]    base_reg,
    input  logic                flush,
    input  logic                uop_ready,
    output logic                uop_valid,
    output logic [IDX_W-1:0]    uop_reg,
    output logic [ADDR_W-1:0]   uop_addr,
    output logic                uop_store,
    output logic                uop_last,
    output logic                uop_wb,
    output logic                stall_out,
    output logic                busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1
`ifdef LM_SM_WRITEBACK_EN
        ,
        S_WB   = 2'd2
`endif
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [NUM_REGS-1:0] r_mask;
    logic [ADDR_W-1:0]   r_addr;
    logic                r_store;

    logic [IDX_W-1:0]    w_sel_idx;
    logic [NUM_REGS-1:0] w_sel_oh;
    logic                w_one_left;
    logic                w_accept;
    logic [ADDR_W-1:0]   w_addr_inc;
    logic                w_mask_nz;

`ifdef LM_SM_WRITEBACK_EN
    logic [IDX_W-1:0]    r_base_reg;
`else
    logic                w_unused_base_reg;
    assign w_unused_base_reg = ^base_reg;
`endif

    // Priority pick of the next register: the last match in scan order wins.
    function automatic logic [IDX_W-1:0] f_pick_idx(input logic [NUM_REGS-1:0] m);
        logic [IDX_W-1:0] idx;
        idx = '0;
        if (LSB_FIRST != 0) begin
            for (int i = NUM_REGS - 1; i >= 0; i--) begin
                if (m[i]) idx = IDX_W'(i);
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (m[i]) idx = IDX_W'(i);
            end
        end
        return idx;
    endfunction

    assign w_sel_idx  = f_pick_idx(r_mask);
    assign w_sel_oh   = NUM_REGS'(1) << w_sel_idx;
    assign w_one_left = ((r_mask & (r_mask - NUM_REGS'(1))) == '0) && (r_mask != '0);
    assign w_accept   = uop_valid & uop_ready;
    assign w_addr_inc = r_addr + ADDR_W'(ADDR_STEP);
    assign w_mask_nz  = (reg_mask != '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_mask  <= '0;
            r_addr  <= '0;
            r_store <= 1'b0;
`ifdef LM_SM_WRITEBACK_EN
            r_base_reg <= '0;
`endif
        end else begin
            r_state <= w_state_nxt;
            if (flush) begin
                r_mask <= '0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (start) begin
                            r_mask  <= reg_mask;
                            r_addr  <= base_addr;
                            r_store <= is_store;
`ifdef LM_SM_WRITEBACK_EN
                            r_base_reg <= base_reg;
`endif
                        end
                    end
                    S_RUN: begin
                        if (w_accept) begin
                            r_mask <= r_mask & ~w_sel_oh;
                            r_addr <= w_addr_inc;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
`ifdef LM_SM_WRITEBACK_EN
                // An empty mask still produces the write-back micro-op.
                if (start) w_state_nxt = w_mask_nz ? S_RUN : S_WB;
`else
                if (start && w_mask_nz) w_state_nxt = S_RUN;
`endif
            end
            S_RUN: begin
                if (w_accept && w_one_left) begin
`ifdef LM_SM_WRITEBACK_EN
                    w_state_nxt = S_WB;
`else
                    w_state_nxt = S_IDLE;
`endif
                end
            end
`ifdef LM_SM_WRITEBACK_EN
            S_WB: begin
                if (uop_ready) w_state_nxt = S_IDLE;
            end
`endif
            default: w_state_nxt = S_IDLE;
        endcase
        if (flush) w_state_nxt = S_IDLE;
    end

    always_comb begin
        uop_valid = 1'b0;
        uop_reg   = '0;
        uop_addr  = '0;
        uop_store = 1'b0;
        uop_last  = 1'b0;
        uop_wb    = 1'b0;
        stall_out = 1'b0;
        busy      = (r_state != S_IDLE);
        case (r_state)
            S_IDLE: begin
`ifdef LM_SM_WRITEBACK_EN
                // Every instruction emits at least the write-back, so always hold upstream.
                stall_out = start;
`else
                stall_out = start & w_mask_nz;
`endif
            end
            S_RUN: begin
                uop_valid = 1'b1;
                uop_reg   = w_sel_idx;
                uop_addr  = r_addr;
                uop_store = r_store;
`ifdef LM_SM_WRITEBACK_EN
                uop_last  = 1'b0;
`else
                uop_last  = w_one_left;
`endif
                stall_out = ~(uop_last & uop_ready);
            end
`ifdef LM_SM_WRITEBACK_EN
            S_WB: begin
                uop_valid = 1'b1;
                uop_reg   = r_base_reg;
                uop_addr  = r_addr;
                uop_last  = 1'b1;
                uop_wb    = 1'b1;
                stall_out = ~uop_ready;
            end
`endif
            default: ;
        endcase
    end

endmodule

// File: tb/tb_lm_sm_seq_gen.sv
// Directed bench for lm_sm_seq_gen: one LSB-first and one MSB-first instance share all inputs.
module tb_lm_sm_seq_gen;

    logic        clk;
    logic        rst;
    logic        start;
    logic        is_store;
    logic [7:0]  reg_mask;
    logic [15:0] base_addr;
    logic [2:0]  base_reg;
    logic        flush;
    logic        uop_ready;

    logic        l_valid, l_store, l_last, l_wb, l_stall, l_busy;
    logic [2:0]  l_reg;
    logic [15:0] l_addr;
    logic        m_valid, m_store, m_last, m_wb, m_stall, m_busy;
    logic [2:0]  m_reg;
    logic [15:0] m_addr;

    int n_checks;
    int n_errors;

    lm_sm_seq_gen #(.NUM_REGS(8), .IDX_W(3), .ADDR_W(16), .ADDR_STEP(1), .LSB_FIRST(1)) u_lsb (
        .clk(clk), .rst(rst), .start(start), .is_store(is_store), .reg_mask(reg_mask),
        .base_addr(base_addr), .base_reg(base_reg), .flush(flush), .uop_ready(uop_ready),
        .uop_valid(l_valid), .uop_reg(l_reg), .uop_addr(l_addr), .uop_store(l_store),
        .uop_last(l_last), .uop_wb(l_wb), .stall_out(l_stall), .busy(l_busy)
    );

    lm_sm_seq_gen #(.NUM_REGS(8), .IDX_W(3), .ADDR_W(16), .ADDR_STEP(1), .LSB_FIRST(0)) u_msb (
        .clk(clk), .rst(rst), .start(start), .is_store(is_store), .reg_mask(reg_mask),
        .base_addr(base_addr), .base_reg(base_reg), .flush(flush), .uop_ready(uop_ready),
        .uop_valid(m_valid), .uop_reg(m_reg), .uop_addr(m_addr), .uop_store(m_store),
        .uop_last(m_last), .uop_wb(m_wb), .stall_out(m_stall), .busy(m_busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [15:0] ea;
        n_checks  = 0;
        n_errors  = 0;
        rst       = 1'b0;
        start     = 1'b0;
        is_store  = 1'b0;
        reg_mask  = 8'h00;
        base_addr = 16'h0000;
        base_reg  = 3'd0;
        flush     = 1'b0;
        uop_ready = 1'b0;

        // Reset state
        #2;
        check_val("rst_valid", l_valid, 0);
        check_val("rst_last",  l_last,  0);
        check_val("rst_wb",    l_wb,    0);
        check_val("rst_busy",  l_busy,  0);
        check_val("rst_reg",   l_reg,   0);
        check_val("rst_addr",  l_addr,  0);
        check_val("rst_store", l_store, 0);
        check_val("rst_stall", l_stall, 0);
        start = 1'b1; reg_mask = 8'h01;
        #1;
        check_val("rst_stall_start", l_stall, 1);
        start = 1'b0; reg_mask = 8'h00;
        @(negedge clk); rst = 1'b1;

        // Reset in the middle of a sequence
        @(negedge clk); start = 1'b1; reg_mask = 8'b1011_0110; base_addr = 16'h0040; is_store = 1'b0; uop_ready = 1'b1;
        #1; check_val("mr_stall0", l_stall, 1);
        @(negedge clk); start = 1'b0; #1;
        check_val("mr_reg0",  l_reg,  1);
        check_val("mr_addr0", l_addr, 16'h0040);
        @(negedge clk); #1;
        check_val("mr_reg1",  l_reg,  2);
        check_val("mr_addr1", l_addr, 16'h0041);
        @(negedge clk); rst = 1'b0; #1;
        check_val("mr_valid", l_valid, 0);
        check_val("mr_busy",  l_busy,  0);
        check_val("mr_reg",   l_reg,   0);
        check_val("mr_addr",  l_addr,  0);
        check_val("mr_last",  l_last,  0);
        check_val("mr_stall", l_stall, 0);
        check_val("mr_mvalid", m_valid, 0);
        @(negedge clk); rst = 1'b1; #1;
        check_val("mr_valid_after", l_valid, 0);
        @(negedge clk); #1;
        check_val("mr_valid_after2", l_valid, 0);
        check_val("mr_busy_after2",  l_busy,  0);

`ifndef LM_SM_WRITEBACK_EN
        // LM, mask 0010_1001, always ready
        @(negedge clk); start = 1'b1; reg_mask = 8'b0010_1001; base_addr = 16'h0100; is_store = 1'b0; uop_ready = 1'b1;
        #1;
        check_val("lm_stall0", l_stall, 1);
        check_val("lm_valid0", l_valid, 0);
        @(negedge clk); start = 1'b0; #1;
        check_val("lm_valid1", l_valid, 1);
        check_val("lm_reg1",   l_reg,   0);
        check_val("lm_addr1",  l_addr,  16'h0100);
        check_val("lm_last1",  l_last,  0);
        check_val("lm_store1", l_store, 0);
        check_val("lm_stall1", l_stall, 1);
        check_val("lm_mreg1",  m_reg,   5);
        @(negedge clk); #1;
        check_val("lm_reg2",   l_reg,   3);
        check_val("lm_addr2",  l_addr,  16'h0101);
        check_val("lm_last2",  l_last,  0);
        check_val("lm_stall2", l_stall, 1);
        check_val("lm_mreg2",  m_reg,   3);
        @(negedge clk); #1;
        check_val("lm_reg3",   l_reg,   5);
        check_val("lm_addr3",  l_addr,  16'h0102);
        check_val("lm_last3",  l_last,  1);
        check_val("lm_stall3", l_stall, 0);
        check_val("lm_mreg3",  m_reg,   0);
        @(negedge clk); #1;
        check_val("lm_valid4", l_valid, 0);
        check_val("lm_busy4",  l_busy,  0);
        check_val("lm_stall4", l_stall, 0);

        // SM, all-ones mask, address wrap, ready toggling
        @(negedge clk); start = 1'b1; reg_mask = 8'hFF; base_addr = 16'hFFFE; is_store = 1'b1; uop_ready = 1'b0;
        #1; check_val("sm_stall0", m_stall, 1);
        for (int j = 0; j < 8; j++) begin
            for (int ph = 0; ph < 2; ph++) begin
                @(negedge clk); start = 1'b0; uop_ready = (ph == 1); #1;
                ea = 16'hFFFE + 16'(j);
                check_val($sformatf("sm_valid_%0d_%0d", j, ph), m_valid, 1);
                check_val($sformatf("sm_reg_%0d_%0d", j, ph),   m_reg,   7 - j);
                check_val($sformatf("sm_addr_%0d_%0d", j, ph),  m_addr,  ea);
                check_val($sformatf("sm_store_%0d_%0d", j, ph), m_store, 1);
                check_val($sformatf("sm_last_%0d_%0d", j, ph),  m_last,  (j == 7) ? 1 : 0);
                check_val($sformatf("sm_stall_%0d_%0d", j, ph), m_stall, (ph == 1 && j == 7) ? 0 : 1);
                check_val($sformatf("sm_lreg_%0d_%0d", j, ph),  l_reg,   j);
            end
        end
        @(negedge clk); uop_ready = 1'b0; #1;
        check_val("sm_valid_end", m_valid, 0);
        check_val("sm_busy_end",  m_busy,  0);

        // Empty mask
        @(negedge clk); start = 1'b1; reg_mask = 8'h00; base_addr = 16'h1234; is_store = 1'b0; uop_ready = 1'b1;
        #1; check_val("em_stall0", l_stall, 0);
        @(negedge clk); start = 1'b0; #1;
        check_val("em_valid1", l_valid, 0);
        check_val("em_busy1",  l_busy,  0);
        check_val("em_stall1", l_stall, 0);
`else
        // Write-back: mask 0000_0011, base 0010, base_reg 6
        @(negedge clk); start = 1'b1; reg_mask = 8'b0000_0011; base_addr = 16'h0010; base_reg = 3'd6; is_store = 1'b1; uop_ready = 1'b1;
        #1; check_val("wb_stall0", l_stall, 1);
        @(negedge clk); start = 1'b0; #1;
        check_val("wb_reg1",  l_reg,  0);
        check_val("wb_addr1", l_addr, 16'h0010);
        check_val("wb_last1", l_last, 0);
        check_val("wb_wb1",   l_wb,   0);
        @(negedge clk); #1;
        check_val("wb_reg2",  l_reg,  1);
        check_val("wb_addr2", l_addr, 16'h0011);
        check_val("wb_last2", l_last, 0);
        check_val("wb_stall2", l_stall, 1);
        @(negedge clk); #1;
        check_val("wb_valid3", l_valid, 1);
        check_val("wb_wb3",    l_wb,    1);
        check_val("wb_reg3",   l_reg,   6);
        check_val("wb_addr3",  l_addr,  16'h0012);
        check_val("wb_last3",  l_last,  1);
        check_val("wb_store3", l_store, 0);
        check_val("wb_stall3", l_stall, 0);
        @(negedge clk); #1;
        check_val("wb_valid4", l_valid, 0);
        check_val("wb_busy4",  l_busy,  0);

        // Write-back with empty mask
        @(negedge clk); start = 1'b1; reg_mask = 8'h00; base_addr = 16'h0055; base_reg = 3'd2;
        @(negedge clk); start = 1'b0; #1;
        check_val("wbe_valid", l_valid, 1);
        check_val("wbe_wb",    l_wb,    1);
        check_val("wbe_reg",   l_reg,   2);
        check_val("wbe_addr",  l_addr,  16'h0055);
        @(negedge clk); #1;
        check_val("wbe_idle",  l_busy,  0);
`endif

        // Flush in the second RUN cycle with ready low
        @(negedge clk); start = 1'b1; reg_mask = 8'b0000_0111; base_addr = 16'h0300; is_store = 1'b0; uop_ready = 1'b0;
        @(negedge clk); start = 1'b0; #1;
        check_val("fl_valid1", l_valid, 1);
        check_val("fl_reg1",   l_reg,   0);
        check_val("fl_addr1",  l_addr,  16'h0300);
        @(negedge clk); flush = 1'b1; #1;
        check_val("fl_valid2", l_valid, 1);
        check_val("fl_reg2",   l_reg,   0);
        @(negedge clk); flush = 1'b0; #1;
        check_val("fl_valid3", l_valid, 0);
        check_val("fl_busy3",  l_busy,  0);
        start = 1'b1; reg_mask = 8'b0000_0010; base_addr = 16'h0200; uop_ready = 1'b1;
        #1; check_val("fl_stall3", l_stall, 1);
        @(negedge clk); start = 1'b0; #1;
        check_val("fl_valid4", l_valid, 1);
        check_val("fl_reg4",   l_reg,   1);
        check_val("fl_addr4",  l_addr,  16'h0200);
`ifndef LM_SM_WRITEBACK_EN
        check_val("fl_last4",  l_last,  1);
        check_val("fl_stall4", l_stall, 0);
`endif
        @(negedge clk); #1;
`ifdef LM_SM_WRITEBACK_EN
        check_val("fl_wb5", l_wb, 1);
        @(negedge clk); #1;
`endif
        check_val("fl_busy5", l_busy, 0);

        // Flush and start together in IDLE: start is dropped
        @(negedge clk); start = 1'b1; flush = 1'b1; reg_mask = 8'h01; base_addr = 16'h0700;
        @(negedge clk); start = 1'b0; flush = 1'b0; #1;
        check_val("fs_busy",  l_busy,  0);
        check_val("fs_valid", l_valid, 0);
        @(negedge clk); #1;
        check_val("fs_busy2", l_busy, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
